// File: rtl/ifm_read_addr_controller.sv
// Walks a stored feature map out of the activation RAM: channel words per window, rows, then tiles.
// Latency: first read strobe the cycle after an accepted start; one bubble per window, one DONE cycle per run.
// Backpressure: ready=0 in READ_CH freezes address, counters and state; the read strobe drops the same cycle.
module ifm_read_addr_controller #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int IFM_RAM_SIZE  = 259584,
    localparam int AW           = $clog2(IFM_RAM_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_read_addr,
    input  logic [8:0]    ifm_size,
    input  logic [15:0]   channel_size,
    input  logic [4:0]    read_ch_size,
    input  logic [8:0]    num_rows,
    input  logic [13:0]   num_tiling,
    input  logic [AW-1:0] tile_addr_incr,
    input  logic          ready,
    output logic [AW-1:0] ifm_addr,
    output logic          ifm_rd_en,
    output logic [4:0]    ifm_rd_size,
    output logic          last_channel,
    output logic          busy,
    output logic          done
);

    localparam logic [4:0] MAX_CH = 5'(SYSTOLIC_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ_CH,
        S_NEXT_WIN,
        S_DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] window_addr;
    logic [AW-1:0] tile_incr;
    logic [15:0]   ch_stride;
    logic [8:0]    row_stride;
    logic [4:0]    ch_cnt;
    logic [4:0]    ch_last;
    logic [8:0]    row_cnt;
    logic [8:0]    row_last;
    logic [13:0]   tile_cnt;
    logic [13:0]   tile_last;

    // Effective per-run limits: zero means one, channel count capped at the array width.
    logic [4:0] eff_rd_size;
    always_comb begin
        eff_rd_size = read_ch_size;
        if (read_ch_size == 5'd0)
            eff_rd_size = 5'd1;
        else if (read_ch_size > MAX_CH)
            eff_rd_size = MAX_CH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ifm_addr    <= '0;
            ifm_rd_size <= '0;
            base_addr   <= '0;
            window_addr <= '0;
            tile_incr   <= '0;
            ch_stride   <= '0;
            row_stride  <= '0;
            ch_cnt      <= '0;
            ch_last     <= '0;
            row_cnt     <= '0;
            row_last    <= '0;
            tile_cnt    <= '0;
            tile_last   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_addr   <= start_read_addr;
                        window_addr <= start_read_addr;
                        ifm_addr    <= start_read_addr;
                        tile_incr   <= tile_addr_incr;
                        ch_stride   <= channel_size;
                        row_stride  <= ifm_size;
                        ifm_rd_size <= eff_rd_size;
                        ch_last     <= eff_rd_size - 5'd1;
                        row_last    <= (num_rows == 9'd0) ? 9'd0 : num_rows - 9'd1;
                        tile_last   <= (num_tiling == 14'd0) ? 14'd0 : num_tiling - 14'd1;
                        ch_cnt      <= '0;
                        row_cnt     <= '0;
                        tile_cnt    <= '0;
                        state       <= S_READ_CH;
                    end
                end
                S_READ_CH: begin
                    if (ready) begin
                        ifm_addr <= ifm_addr + AW'(ch_stride);
                        if (ch_cnt == ch_last) begin
                            ch_cnt <= '0;
                            state  <= S_NEXT_WIN;
                        end else begin
                            ch_cnt <= ch_cnt + 5'd1;
                        end
                    end
                end
                S_NEXT_WIN: begin
                    if (row_cnt != row_last) begin
                        row_cnt     <= row_cnt + 9'd1;
                        window_addr <= window_addr + AW'(row_stride);
                        ifm_addr    <= window_addr + AW'(row_stride);
                        state       <= S_READ_CH;
                    end else if (tile_cnt != tile_last) begin
                        row_cnt     <= '0;
                        tile_cnt    <= tile_cnt + 14'd1;
                        base_addr   <= base_addr + tile_incr;
                        window_addr <= base_addr + tile_incr;
                        ifm_addr    <= base_addr + tile_incr;
                        state       <= S_READ_CH;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ifm_rd_en    = (state == S_READ_CH) && ready;
    assign last_channel = ifm_rd_en && (ch_cnt == ch_last);
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);

endmodule

// File: tb/tb_ifm_read_addr_controller.sv
// Bench for ifm_read_addr_controller: table of hand-computed runs plus stall, restart and reset sequences.
module tb_ifm_read_addr_controller;

    localparam int AW   = 18;
    localparam int MASK = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_read_addr = '0;
    logic [8:0]    ifm_size = '0;
    logic [15:0]   channel_size = '0;
    logic [4:0]    read_ch_size = '0;
    logic [8:0]    num_rows = '0;
    logic [13:0]   num_tiling = '0;
    logic [AW-1:0] tile_addr_incr = '0;
    logic          ready = 1'b1;
    logic [AW-1:0] ifm_addr;
    logic          ifm_rd_en;
    logic [4:0]    ifm_rd_size;
    logic          last_channel;
    logic          busy;
    logic          done;

    ifm_read_addr_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .start_read_addr(start_read_addr), .ifm_size(ifm_size),
        .channel_size(channel_size), .read_ch_size(read_ch_size),
        .num_rows(num_rows), .num_tiling(num_tiling),
        .tile_addr_incr(tile_addr_incr), .ready(ready),
        .ifm_addr(ifm_addr), .ifm_rd_en(ifm_rd_en), .ifm_rd_size(ifm_rd_size),
        .last_channel(last_channel), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr; int ch; int rd; int ifm; int rows; int tiles; int incr;
        int nreads; int last; int done_cyc; int rdsz;
    } vec_t;

    vec_t vecs[6];
    int total = 0;
    int bad = 0;
    int exp_addr[$];
    int exp_lastc[$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference read list as a plain nested loop over tiles, rows and channels.
    task automatic build_model(input vec_t v);
        int nrd, nrow, ntile;
        longint a;
        nrd   = (v.rd == 0) ? 1 : ((v.rd > 16) ? 16 : v.rd);
        nrow  = (v.rows == 0) ? 1 : v.rows;
        ntile = (v.tiles == 0) ? 1 : v.tiles;
        exp_addr.delete();
        exp_lastc.delete();
        for (int t = 0; t < ntile; t++)
            for (int r = 0; r < nrow; r++)
                for (int c = 0; c < nrd; c++) begin
                    a = longint'(v.addr) + longint'(t) * v.incr + longint'(r) * v.ifm + longint'(c) * v.ch;
                    exp_addr.push_back(int'(a & MASK));
                    exp_lastc.push_back((c == nrd - 1) ? 1 : 0);
                end
    endtask

    // Called mid-cycle while idle; returns mid-cycle in the idle cycle after done.
    task automatic run(input string tag, input int vi, input int stall_s, input int stall_n, input int poke_cyc);
        vec_t v;
        int cyc, nread, done_cyc, last_a, busy_ok, stall_ok, rdsz;
        v = vecs[vi];
        build_model(v);
        start_read_addr = AW'(v.addr);
        channel_size    = 16'(v.ch);
        read_ch_size    = 5'(v.rd);
        ifm_size        = 9'(v.ifm);
        num_rows        = 9'(v.rows);
        num_tiling      = 14'(v.tiles);
        tile_addr_incr  = AW'(v.incr);
        ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Config changes after acceptance must not leak into the run.
        start_read_addr = 18'd5000; channel_size = 16'd7; read_ch_size = 5'd9;
        ifm_size = 9'd3; num_rows = 9'd5; num_tiling = 14'd4; tile_addr_incr = 18'd77;
        nread = 0; done_cyc = -1; last_a = -1; busy_ok = 1; stall_ok = 1; rdsz = -1;
        for (cyc = 1; cyc <= 400; cyc++) begin
            ready = !(cyc >= stall_s && cyc < stall_s + stall_n);
            start = (cyc == poke_cyc);
            #1;
            if (cyc == 1) rdsz = int'(ifm_rd_size);
            if (!busy) busy_ok = 0;
            if (!ready && nread < exp_addr.size())
                if (ifm_rd_en || int'(ifm_addr) != exp_addr[nread]) stall_ok = 0;
            if (ifm_rd_en) begin
                if (nread < exp_addr.size()) begin
                    chk({tag, " addr"}, ifm_addr, exp_addr[nread]);
                    chk({tag, " last_channel"}, last_channel, exp_lastc[nread]);
                end
                last_a = int'(ifm_addr);
                nread++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        ready = 1'b1;
        chk({tag, " reads"}, nread, v.nreads);
        chk({tag, " last addr"}, last_a, v.last);
        chk({tag, " done cycle"}, done_cyc, v.done_cyc + stall_n);
        chk({tag, " rd_size"}, rdsz, v.rdsz);
        chk({tag, " busy during run"}, busy_ok, 1);
        if (stall_n > 0) chk({tag, " stall hold"}, stall_ok, 1);
        @(posedge clk); #2;
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " idle done"}, done, 0);
    endtask

    initial begin
        //          addr    ch   rd ifm rows tiles incr  nreads last   done rdsz
        vecs[0] = '{100,    169, 3, 13, 2,   1,    0,    6,     451,   9,   3};
        vecs[1] = '{100,    169, 2, 13, 1,   2,    1000, 4,     1269,  7,   2};
        vecs[2] = '{262134, 16,  2, 13, 1,   1,    0,    2,     6,     4,   2};
        vecs[3] = '{50,     10,  0, 7,  3,   2,    500,  6,     564,   13,  1};
        vecs[4] = '{0,      1,   20, 4, 1,   1,    0,    16,    15,    18,  16};
        vecs[5] = '{7,      3,   1, 2,  0,   0,    9,    1,     7,     3,   1};

        #12;
        chk("reset addr", ifm_addr, 0);
        chk("reset rd_en", ifm_rd_en, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rd_size", ifm_rd_size, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;

        for (int i = 0; i < 6; i++)
            run($sformatf("vec%0d", i), i, 0, 0, -1);

        run("stall", 0, 2, 3, -1);
        // Start mid-run is ignored, then a start in the idle cycle after done is taken.
        run("restart_ignored", 0, 0, 0, 3);
        run("start_after_done", 1, 0, 0, -1);

        // Reset while the second window is reading 282.
        start_read_addr = 18'd100; channel_size = 16'd169; read_ch_size = 5'd3;
        ifm_size = 9'd13; num_rows = 9'd2; num_tiling = 14'd1; tile_addr_incr = 18'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 6; k++) begin
            @(posedge clk); #1;
        end
        #1;
        chk("pre-reset addr", ifm_addr, 282);
        rst_n = 1'b0;
        #1;
        chk("async reset addr", ifm_addr, 0);
        chk("async reset rd_en", ifm_rd_en, 0);
        chk("async reset busy", busy, 0);
        chk("async reset rd_size", ifm_rd_size, 0);
        chk("async reset last_channel", last_channel, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int saw_done, saw_busy;
            saw_done = 0; saw_busy = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #2;
                if (done) saw_done = 1;
                if (busy) saw_busy = 1;
            end
            chk("no done after reset", saw_done, 0);
            chk("stays idle after reset", saw_busy, 0);
        end
        run("post-reset", 1, 0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
